// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store memory controller: RV32 width codes,
// FSM state encoding and width/legality helpers.
package lsu_mem_ctrl_pkg;

   localparam logic [2:0] F3_B        = 3'b000;
   localparam logic [2:0] F3_H        = 3'b001;
   localparam logic [2:0] F3_W        = 3'b010;
   localparam logic [2:0] F3_BU       = 3'b100;
   localparam logic [2:0] F3_HU       = 3'b101;
   localparam logic [2:0] MEM_F3_WORD = 3'b010;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD0,
      S_RD1,
      S_WR0,
      S_WR1,
      S_RESP
   } state_e;

   // Access size in bytes from the low two bits of funct3.
   function automatic logic [2:0] size_of(input logic [1:0] width);
      case (width)
         2'b00:   size_of = 3'd1;
         2'b01:   size_of = 3'd2;
         default: size_of = 3'd4;
      endcase
   endfunction

   function automatic logic f3_legal(input logic [2:0] f3, input logic we);
      case (f3)
         F3_B, F3_H, F3_W: f3_legal = 1'b1;
         F3_BU, F3_HU:     f3_legal = ~we;
         default:          f3_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_mem_ctrl_lane_align.sv
// Byte-lane steering between a pair of little-endian memory words and the core:
// extracts/extends load data and merges store data into the two words.
module lsu_lane_align
   import lsu_mem_ctrl_pkg::*;
(
   input  logic [31:0] word0_i,
   input  logic [31:0] word1_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] ld_data_o,
   output logic [31:0] st_word0_o,
   output logic [31:0] st_word1_o
);

   logic [63:0] pair;
   logic [63:0] st_mask;
   logic [63:0] st_data;
   logic [63:0] merged;
   logic [31:0] ld_word;
   logic [5:0]  shamt;

   always_comb begin
      shamt   = {1'b0, off_i, 3'b000};
      pair    = {word1_i, word0_i};
      // Bytes starting at the offset, spilling into word1 when the access crosses.
      ld_word = pair[shamt +: 32];

      case (funct3_i)
         F3_B:    ld_data_o = {{24{ld_word[7]}}, ld_word[7:0]};
         F3_H:    ld_data_o = {{16{ld_word[15]}}, ld_word[15:0]};
         F3_W:    ld_data_o = ld_word;
         F3_BU:   ld_data_o = {24'b0, ld_word[7:0]};
         F3_HU:   ld_data_o = {16'b0, ld_word[15:0]};
         default: ld_data_o = 32'b0;
      endcase

      case (funct3_i[1:0])
         2'b00:   st_mask = 64'h0000_0000_0000_00FF;
         2'b01:   st_mask = 64'h0000_0000_0000_FFFF;
         default: st_mask = 64'h0000_0000_FFFF_FFFF;
      endcase
      st_mask = st_mask << shamt;
      st_data = {32'b0, wdata_i} << shamt;
      merged  = (pair & ~st_mask) | (st_data & st_mask);
   end

   assign st_word0_o = merged[31:0];
   assign st_word1_o = merged[63:32];

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: turns arbitrary-alignment byte/half/word requests into
// aligned word reads and read-modify-write sequences on the data-memory port.
module lsu_mem_ctrl
   import lsu_mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [2:0]        mem_funct3,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_e            state_q;
   logic              we_q;
   logic [2:0]        f3_q;
   logic [1:0]        off_q;
   logic [31:0]       wdata_q;
   logic [ADDR_W-1:0] a0_q;
   logic [ADDR_W-1:0] a1_q;
   logic              cross_q;
   logic [31:0]       word0_q;
   logic [31:0]       word1_q;

   logic              resp_valid_q;
   logic [31:0]       resp_rdata_q;
   logic              resp_err_q;
   logic              mem_read_q;
   logic              mem_write_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_wdata_q;

   logic [ADDR_W-1:0] req_a0;
   logic [ADDR_W-1:0] req_a1;
   logic [2:0]        req_span;
   logic              req_cross;
   logic              req_legal;
   logic [31:0]       lane_w0;
   logic [31:0]       lane_w1;
   logic [31:0]       ld_data;
   logic [31:0]       st_word0;
   logic [31:0]       st_word1;

   always_comb begin
      req_a0    = {req_addr[ADDR_W-1:2], 2'b00};
      req_a1    = req_a0 + ADDR_W'(4);
      req_span  = {1'b0, req_addr[1:0]} + size_of(req_funct3[1:0]);
      req_cross = (req_span > 3'd4);
      req_legal = f3_legal(req_funct3, req_we);
      // The word being read this cycle feeds the aligner directly so the
      // merge/extract result can be registered on the same edge.
      lane_w0   = (state_q == S_RD0) ? mem_rdata : word0_q;
      lane_w1   = (state_q == S_RD1) ? mem_rdata : word1_q;
   end

   lsu_lane_align u_align (
      .word0_i    (lane_w0),
      .word1_i    (lane_w1),
      .off_i      (off_q),
      .funct3_i   (f3_q),
      .wdata_i    (wdata_q),
      .ld_data_o  (ld_data),
      .st_word0_o (st_word0),
      .st_word1_o (st_word1)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         we_q         <= 1'b0;
         f3_q         <= 3'b0;
         off_q        <= 2'b0;
         wdata_q      <= 32'b0;
         a0_q         <= '0;
         a1_q         <= '0;
         cross_q      <= 1'b0;
         word0_q      <= 32'b0;
         word1_q      <= 32'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'b0;
         resp_err_q   <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= 32'b0;
      end else begin
         resp_valid_q <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  f3_q    <= req_funct3;
                  off_q   <= req_addr[1:0];
                  wdata_q <= req_wdata;
                  a0_q    <= req_a0;
                  a1_q    <= req_a1;
                  cross_q <= req_cross;
                  if (!req_legal) begin
                     state_q      <= S_RESP;
                     resp_valid_q <= 1'b1;
                     resp_rdata_q <= 32'b0;
                     resp_err_q   <= 1'b1;
                  end else if (req_we && req_funct3 == F3_W && req_addr[1:0] == 2'b00) begin
                     // Full aligned word: nothing to preserve, skip the read.
                     state_q     <= S_WR0;
                     mem_write_q <= 1'b1;
                     mem_addr_q  <= req_a0;
                     mem_wdata_q <= req_wdata;
                  end else begin
                     state_q    <= S_RD0;
                     mem_read_q <= 1'b1;
                     mem_addr_q <= req_a0;
                  end
               end
            end
            S_RD0: begin
               word0_q <= mem_rdata;
               if (cross_q) begin
                  state_q    <= S_RD1;
                  mem_read_q <= 1'b1;
                  mem_addr_q <= a1_q;
               end else if (we_q) begin
                  state_q     <= S_WR0;
                  mem_write_q <= 1'b1;
                  mem_addr_q  <= a0_q;
                  mem_wdata_q <= st_word0;
               end else begin
                  state_q      <= S_RESP;
                  resp_valid_q <= 1'b1;
                  resp_rdata_q <= ld_data;
                  resp_err_q   <= 1'b0;
               end
            end
            S_RD1: begin
               word1_q <= mem_rdata;
               if (we_q) begin
                  state_q     <= S_WR0;
                  mem_write_q <= 1'b1;
                  mem_addr_q  <= a0_q;
                  mem_wdata_q <= st_word0;
               end else begin
                  state_q      <= S_RESP;
                  resp_valid_q <= 1'b1;
                  resp_rdata_q <= ld_data;
                  resp_err_q   <= 1'b0;
               end
            end
            S_WR0: begin
               if (cross_q) begin
                  state_q     <= S_WR1;
                  mem_write_q <= 1'b1;
                  mem_addr_q  <= a1_q;
                  mem_wdata_q <= st_word1;
               end else begin
                  state_q      <= S_RESP;
                  resp_valid_q <= 1'b1;
                  resp_rdata_q <= 32'b0;
                  resp_err_q   <= 1'b0;
               end
            end
            S_WR1: begin
               state_q      <= S_RESP;
               resp_valid_q <= 1'b1;
               resp_rdata_q <= 32'b0;
               resp_err_q   <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready  = (state_q == S_IDLE) && !rst;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign mem_read   = mem_read_q;
   assign mem_write  = mem_write_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_funct3 = MEM_F3_WORD;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl against a 16-word data memory model.
module tb_lsu_mem_ctrl;

   typedef struct packed {
      logic        wr;
      logic [5:0]  addr;
      logic [31:0] wdata;
   } acc_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
      int          lat;
   } resp_t;

   typedef struct packed {
      logic [3:0]  idx;
      logic [31:0] exp;
   } memchk_t;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [5:0]  req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_read;
   logic        mem_write;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:15];
   logic        bd_we;
   logic [3:0]  bd_idx;
   logic [31:0] bd_data;

   acc_t    acc_q[$];
   resp_t   resp_q[$];
   memchk_t memchk_q[$];

   int cyc;
   int checks;
   int errors;
   int tmo_events;
   logic end_req;
   logic end_ack;
   logic rst_d1;

   lsu_mem_ctrl #(.ADDR_W(6), .DATA_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_funct3 (mem_funct3),
      .mem_rdata  (mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Data memory: combinational read, write on the rising edge, plus a backdoor port.
   assign mem_rdata = mem_read ? mem[mem_addr[5:2]] : 32'h0;
   always @(posedge clk) begin
      if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;
      if (bd_we)     mem[bd_idx]        <= bd_data;
   end

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      rst_d1 <= rst;
   end

   // Monitor: all comparisons happen here, on the falling edge.
   initial begin
      logic rst_prev;
      rst_prev = 1'b0;
      checks   = 0;
      errors   = 0;
      end_ack  = 1'b0;
      forever begin
         @(negedge clk);
         if (rst && rst_d1) begin
            checks++;
            if (req_ready || resp_valid || resp_err || mem_read || mem_write ||
                resp_rdata != 32'h0 || mem_addr != 6'h0 || mem_wdata != 32'h0) begin
               errors++;
               $display("FAIL reset_state ready=%0d rv=%0d err=%0d rd=%0d wr=%0d rdata=%h addr=%h wdata=%h required all 0",
                        req_ready, resp_valid, resp_err, mem_read, mem_write, resp_rdata, mem_addr, mem_wdata);
            end
         end
         if (!rst && rst_prev) begin
            checks++;
            if (!req_ready) begin
               errors++;
               $display("FAIL ready_after_reset req_ready=%0d required 1", req_ready);
            end
         end
         rst_prev = rst;

         if (mem_read && mem_write) begin
            checks++;
            errors++;
            $display("FAIL rd_wr_overlap mem_read=1 mem_write=1 required not both");
         end else if (mem_read || mem_write) begin
            checks++;
            if (acc_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_access wr=%0d addr=%h wdata=%h required none", mem_write, mem_addr, mem_wdata);
            end else begin
               if (acc_q[0].wr != mem_write || acc_q[0].addr != mem_addr ||
                   (acc_q[0].wr && acc_q[0].wdata != mem_wdata) || mem_funct3 != 3'b010) begin
                  errors++;
                  $display("FAIL access wr=%0d addr=%h wdata=%h f3=%b required wr=%0d addr=%h wdata=%h f3=010",
                           mem_write, mem_addr, mem_wdata, mem_funct3, acc_q[0].wr, acc_q[0].addr, acc_q[0].wdata);
               end
               void'(acc_q.pop_front());
            end
         end

         if (resp_valid) begin
            checks++;
            if (resp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_resp rdata=%h err=%0d required none", resp_rdata, resp_err);
            end else begin
               if (resp_rdata != resp_q[0].rdata || resp_err != resp_q[0].err ||
                   (cyc - resp_q[0].acc + 1) != resp_q[0].lat) begin
                  errors++;
                  $display("FAIL resp rdata=%h err=%0d lat=%0d required rdata=%h err=%0d lat=%0d",
                           resp_rdata, resp_err, cyc - resp_q[0].acc + 1,
                           resp_q[0].rdata, resp_q[0].err, resp_q[0].lat);
               end
               void'(resp_q.pop_front());
            end
         end

         while (memchk_q.size() != 0) begin
            checks++;
            if (mem[memchk_q[0].idx] != memchk_q[0].exp) begin
               errors++;
               $display("FAIL mem_content word=%0d got=%h required=%h",
                        memchk_q[0].idx, mem[memchk_q[0].idx], memchk_q[0].exp);
            end
            void'(memchk_q.pop_front());
         end

         if (end_req && !end_ack) begin
            checks++;
            if (acc_q.size() != 0 || resp_q.size() != 0 || tmo_events != 0) begin
               errors++;
               $display("FAIL drain pending_acc=%0d pending_resp=%0d timeouts=%0d required 0 0 0",
                        acc_q.size(), resp_q.size(), tmo_events);
            end
            end_ack = 1'b1;
         end
      end
   end

   task automatic exp_rd(input logic [5:0] a);
      acc_q.push_back('{wr: 1'b0, addr: a, wdata: 32'h0});
   endtask

   task automatic exp_wr(input logic [5:0] a, input logic [31:0] d);
      acc_q.push_back('{wr: 1'b1, addr: a, wdata: d});
   endtask

   task automatic bd_write(input logic [3:0] idx, input logic [31:0] d);
      @(negedge clk);
      bd_we   = 1'b1;
      bd_idx  = idx;
      bd_data = d;
      @(negedge clk);
      bd_we   = 1'b0;
   endtask

   task automatic issue(input logic we, input logic [2:0] f3, input logic [5:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rdata,
                        input logic exp_err, input int lat, input bit push_resp);
      int waited;
      waited = 0;
      @(negedge clk);
      while (!req_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) begin
         tmo_events++;
         return;
      end
      if (push_resp) resp_q.push_back('{rdata: exp_rdata, err: exp_err, acc: cyc + 1, lat: lat});
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      // Scramble the request after the accept edge; the DUT must ignore it.
      req_valid  = 1'b0;
      req_we     = ~we;
      req_funct3 = 3'b111;
      req_addr   = 6'h2A;
      req_wdata  = 32'h5A5A_5A5A;
   endtask

   task automatic wait_drain();
      int waited;
      waited = 0;
      @(negedge clk);
      while ((acc_q.size() != 0 || resp_q.size() != 0 || !req_ready) && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 50) tmo_events++;
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b0;
      req_addr   = 6'h0;
      req_wdata  = 32'h0;
      bd_we      = 1'b0;
      bd_idx     = 4'h0;
      bd_data    = 32'h0;
      tmo_events = 0;
      end_req    = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;

      // 1: aligned SW, no read
      exp_wr(6'd8, 32'hDEAD_BEEF);
      issue(1'b1, 3'b010, 6'd8, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1'b1);
      wait_drain();

      // 2: SB read-modify-write, then LB/LBU of the stored byte
      bd_write(4'd3, 32'h1122_3344);
      exp_rd(6'd12);
      exp_wr(6'd12, 32'h1122_EF44);
      issue(1'b1, 3'b000, 6'd13, 32'h0000_00EF, 32'h0, 1'b0, 3, 1'b1);
      exp_rd(6'd12);
      issue(1'b0, 3'b000, 6'd13, 32'h0, 32'hFFFF_FFEF, 1'b0, 2, 1'b1);
      exp_rd(6'd12);
      issue(1'b0, 3'b100, 6'd13, 32'h0, 32'h0000_00EF, 1'b0, 2, 1'b1);
      wait_drain();

      // 3: crossing SW and LW at addr 10
      bd_write(4'd2, 32'h0);
      bd_write(4'd3, 32'h0);
      exp_rd(6'd8);
      exp_rd(6'd12);
      exp_wr(6'd8, 32'hCCDD_0000);
      exp_wr(6'd12, 32'h0000_AABB);
      issue(1'b1, 3'b010, 6'd10, 32'hAABB_CCDD, 32'h0, 1'b0, 5, 1'b1);
      exp_rd(6'd8);
      exp_rd(6'd12);
      issue(1'b0, 3'b010, 6'd10, 32'h0, 32'hAABB_CCDD, 1'b0, 3, 1'b1);
      // Non-crossing SH into the upper half of @12, then read both halves back
      exp_rd(6'd12);
      exp_wr(6'd12, 32'hBEEF_AABB);
      issue(1'b1, 3'b001, 6'd14, 32'h1234_BEEF, 32'h0, 1'b0, 3, 1'b1);
      exp_rd(6'd12);
      issue(1'b0, 3'b101, 6'd12, 32'h0, 32'h0000_AABB, 1'b0, 2, 1'b1);
      exp_rd(6'd12);
      issue(1'b0, 3'b001, 6'd14, 32'h0, 32'hFFFF_BEEF, 1'b0, 2, 1'b1);
      wait_drain();

      // 4: crossing halfword with address wrap 63 -> 0
      bd_write(4'd15, 32'h8000_0000);
      bd_write(4'd0, 32'h0000_00FF);
      exp_rd(6'd60);
      exp_rd(6'd0);
      issue(1'b0, 3'b001, 6'd63, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 1'b1);
      exp_rd(6'd60);
      exp_rd(6'd0);
      issue(1'b0, 3'b101, 6'd63, 32'h0, 32'h0000_FF80, 1'b0, 3, 1'b1);
      wait_drain();

      // 5: illegal funct3 codes, no memory traffic
      issue(1'b0, 3'b011, 6'd4, 32'h0, 32'h0, 1'b1, 1, 1'b1);
      issue(1'b1, 3'b100, 6'd4, 32'h1111_1111, 32'h0, 1'b1, 1, 1'b1);
      issue(1'b0, 3'b111, 6'd5, 32'h0, 32'h0, 1'b1, 1, 1'b1);
      wait_drain();

      // 6: reset during WR0 of a crossing store
      bd_write(4'd2, 32'h0);
      bd_write(4'd3, 32'h0);
      exp_rd(6'd8);
      exp_rd(6'd12);
      exp_wr(6'd8, 32'h3344_0000);
      issue(1'b1, 3'b010, 6'd10, 32'h1122_3344, 32'h0, 1'b0, 0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      memchk_q.push_back('{idx: 4'd2, exp: 32'h3344_0000});
      memchk_q.push_back('{idx: 4'd3, exp: 32'h0});
      exp_rd(6'd8);
      issue(1'b0, 3'b010, 6'd8, 32'h0, 32'h3344_0000, 1'b0, 2, 1'b1);
      wait_drain();

      repeat (2) @(negedge clk);
      end_req = 1'b1;
      repeat (3) @(negedge clk);
      if (!end_ack) begin
         $display("FAIL monitor_stalled end_ack=0 required 1");
         $fatal(1, "monitor did not acknowledge");
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
